// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data load/store, with an in-order ID FIFO for responses.
// Optional build macro SRAM_ARB_RR_EN: round-robin arbitration instead of fixed data-over-inst priority.
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic              err_unexp
);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic {GNT_INST, GNT_DATA} grant_t;

    state_t                 state;
    grant_t                 hold_id;
    grant_t                 grant;
    logic [OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   head;
`ifdef SRAM_ARB_RR_EN
    grant_t                 last_grant;
`endif

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps the port until accepted, whatever the other side does.
    always_comb begin
        if (state == HOLD) begin
            grant = hold_id;
        end else if (data_req) begin
`ifdef SRAM_ARB_RR_EN
            grant = (inst_req && last_grant == GNT_DATA) ? GNT_INST : GNT_DATA;
`else
            grant = GNT_DATA;
`endif
        end else begin
            grant = GNT_INST;
        end
    end

    assign fifo_full  = (count == CNT_W'(OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = id_fifo[rd_ptr];

    assign mem_req = (inst_req | data_req | (state == HOLD)) & ~fifo_full & ~reset;
    assign push    = mem_req & mem_addr_ok;
    assign pop     = mem_data_ok & ~fifo_empty & ~reset;

    assign inst_addr_ok = push & (grant == GNT_INST);
    assign data_addr_ok = push & (grant == GNT_DATA);
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (mem_req) begin
            if (grant == GNT_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wr ? data_wstrb : 4'd0;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_id   <= GNT_INST;
            id_fifo   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_unexp <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant <= GNT_INST;
`endif
        end else begin
            case (state)
                IDLE: if (mem_req && !mem_addr_ok) begin
                    state   <= HOLD;
                    hold_id <= grant;
                end
                HOLD: if (mem_addr_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push) begin
                id_fifo[wr_ptr] <= (grant == GNT_DATA);
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (mem_data_ok && fifo_empty) err_unexp <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            if (push) last_grant <= grant;
`endif
        end
    end
endmodule
